// File: rtl/axis_arb_pkg.sv
// Shared state encoding and rotating-priority helper for the packet round-robin arbiter.
// Sized for up to MAX_PORTS requesters; callers zero-pad narrower request masks.
package axis_arb_pkg;

  localparam int MAX_PORTS = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // First set bit of mask scanning last+1, last+2, ... modulo n.
  function automatic logic [2:0] rr_next(input logic [MAX_PORTS-1:0] mask,
                                         input logic [2:0]           last,
                                         input int                   n);
    logic [2:0] pick;
    logic [2:0] cidx;
    logic       found;
    int         cand;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      cand = (int'(last) + k) % n;
      cidx = cand[2:0];
      if (!found && (k <= n) && mask[cidx]) begin
        pick  = cidx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: picks the first requester after last_i, purely combinational.
// No latency, no backpressure; any_req_o flags that the winner is meaningful.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic [$clog2(NUM_PORTS)-1:0] last_i,
  output logic [$clog2(NUM_PORTS)-1:0] winner_o,
  output logic                         any_req_o
);

  localparam int IW = $clog2(NUM_PORTS);

  logic [MAX_PORTS-1:0] mask;

  always_comb begin
    mask                = '0;
    mask[NUM_PORTS-1:0] = req_i;
  end

  assign winner_o  = IW'(rr_next(mask, 3'(last_i), NUM_PORTS));
  assign any_req_o = |req_i;

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-locked round-robin AXI-Stream arbiter; first beat one cycle after request, one idle cycle between packets.
// Master TREADY passes straight to the granted slave only; optional AXIS_ARB_MAX_BEATS_EN splits packets at MAX_BEATS.
module axis_pkt_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS          = 4,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_BEATS          = 16
) (
  input  logic                                      M_AXIS_ACLK,
  input  logic                                      M_AXIS_ARESET,
  input  logic [NUM_PORTS-1:0]                      S_AXIS_TVALID,
  input  logic [NUM_PORTS*C_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [NUM_PORTS*C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [NUM_PORTS-1:0]                      S_AXIS_TLAST,
  output logic [NUM_PORTS-1:0]                      S_AXIS_TREADY,
  output logic                                      M_AXIS_TVALID,
  output logic [C_AXIS_TDATA_WIDTH-1:0]             M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]           M_AXIS_TSTRB,
  output logic                                      M_AXIS_TLAST,
  input  logic                                      M_AXIS_TREADY,
  output logic [$clog2(NUM_PORTS)-1:0]              GRANT_ID,
  output logic                                      BUSY
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int SW = C_AXIS_TDATA_WIDTH / 8;

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("NUM_PORTS must be 2..8");
  end
  if (MAX_BEATS < 1) begin : g_bad_beats
    $error("MAX_BEATS must be at least 1");
  end

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] winner;
  logic          any_req;

  logic          sel_vld, sel_last, beat_cap, m_acc;
  logic [W-1:0]  sel_dat;
  logic [SW-1:0] sel_strb;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req_i     (S_AXIS_TVALID),
    .last_i    (last_grant_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  assign sel_vld  = S_AXIS_TVALID[grant_q];
  assign sel_last = S_AXIS_TLAST[grant_q];
  assign sel_dat  = S_AXIS_TDATA[grant_q*W +: W];
  assign sel_strb = S_AXIS_TSTRB[grant_q*SW +: SW];

`ifdef AXIS_ARB_MAX_BEATS_EN
  localparam int CW = $clog2(MAX_BEATS + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // The MAX_BEATS-th accepted beat of a grant closes the packet.
  assign beat_cap = (cnt_q == CW'(MAX_BEATS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (m_acc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign beat_cap = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TSTRB  = '0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = '0;
    m_acc         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        M_AXIS_TVALID = sel_vld;
        // Data fields stay zero while the granted source stalls.
        if (sel_vld) begin
          M_AXIS_TDATA = sel_dat;
          M_AXIS_TSTRB = sel_strb;
          M_AXIS_TLAST = sel_last | beat_cap;
        end
        S_AXIS_TREADY[grant_q] = M_AXIS_TREADY;
        m_acc = sel_vld & M_AXIS_TREADY;
        if (m_acc && M_AXIS_TLAST) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign GRANT_ID = grant_q;
  assign BUSY     = (state_q == ST_STREAM);

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Randomised bench for axis_pkt_rr_arbiter against a queue-based packet arbitration model.
// Sources hold TVALID until handshake; the model predicts every master-side output each cycle.
module tb_axis_pkt_rr_arbiter;

  localparam int NP = 4;
  localparam int W  = 32;
  localparam int SW = 4;
  localparam int MB = 4;
`ifdef AXIS_ARB_MAX_BEATS_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     s_vld, s_last, s_rdy;
  logic [NP*W-1:0]   s_dat;
  logic [NP*SW-1:0]  s_strb;
  logic              m_vld, m_last, m_rdy, busy;
  logic [W-1:0]      m_dat;
  logic [SW-1:0]     m_strb;
  logic [1:0]        gid;

  axis_pkt_rr_arbiter #(
    .NUM_PORTS(NP), .C_AXIS_TDATA_WIDTH(W), .MAX_BEATS(MB)
  ) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst),
    .S_AXIS_TVALID(s_vld), .S_AXIS_TDATA(s_dat), .S_AXIS_TSTRB(s_strb),
    .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_rdy),
    .M_AXIS_TVALID(m_vld), .M_AXIS_TDATA(m_dat), .M_AXIS_TSTRB(m_strb),
    .M_AXIS_TLAST(m_last), .M_AXIS_TREADY(m_rdy),
    .GRANT_ID(gid), .BUSY(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Source queues: {last, strb, data} per beat.
  logic [36:0] srcq [NP][$];
  logic [NP-1:0] hold;
  logic [NP-1:0] gate;
  int unsigned vld_pct, rdy_pct;
  bit          rdy_mode;
  int          cyc = 0;

  // Model state: packet owner, previous owner, grant id, beats in current grant.
  bit m_busy;
  int m_owner, m_prev, m_gid, m_cnt;
  logic [32:0] acc_log [$];
  int          own_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mkdat(input int p, input int t, input int b);
    return {8'(p), 8'(t), 8'(b), 8'hA5};
  endfunction

  task automatic add_pkt(input int p, input int len, input int t);
    logic [3:0] st;
    for (int b = 0; b < len; b++) begin
      st = 4'($urandom_range(15, 1));
      srcq[p].push_back({(b == len - 1), st, mkdat(p, t, b)});
    end
  endtask

  function automatic bit pending();
    bit r;
    r = m_busy;
    for (int p = 0; p < NP; p++) if (srcq[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic step(input logic r);
    logic [36:0]   h;
    logic          e_vld, e_last, acc;
    logic [W-1:0]  e_dat;
    logic [SW-1:0] e_strb;
    logic [NP-1:0] e_rdy, hs;
    bit            found;
    int            c;
    for (int p = 0; p < NP; p++) begin
      if (!hold[p]) s_vld[p] = gate[p] && (srcq[p].size() > 0) && ($urandom_range(99) < vld_pct);
      if (s_vld[p]) begin
        h = srcq[p][0];
        s_dat[p*W +: W]    = h[31:0];
        s_strb[p*SW +: SW] = h[35:32];
        s_last[p]          = h[36];
      end else begin
        s_dat[p*W +: W]    = $urandom;
        s_strb[p*SW +: SW] = 4'($urandom);
        s_last[p]          = 1'($urandom);
      end
    end
    m_rdy = rdy_mode ? (cyc % 3 == 0) : ($urandom_range(99) < rdy_pct);
    rst = r;
    #3;
    e_vld = 1'b0; e_last = 1'b0; e_dat = '0; e_strb = '0; e_rdy = '0;
    if (m_busy) begin
      e_vld = s_vld[m_owner];
      if (e_vld) begin
        h      = srcq[m_owner][0];
        e_dat  = h[31:0];
        e_strb = h[35:32];
        e_last = h[36] | (FEAT && m_cnt == MB - 1);
      end
      e_rdy[m_owner] = m_rdy;
    end
    chk("m_tvalid", m_vld, e_vld);
    chk("m_tdata", m_dat, e_dat);
    chk("m_tstrb", m_strb, e_strb);
    chk("m_tlast", m_last, e_last);
    chk("s_tready", s_rdy, e_rdy);
    chk("grant_id", gid, m_gid);
    chk("busy", busy, m_busy);
    acc = m_busy && e_vld && m_rdy;
    if (acc) acc_log.push_back({e_last, e_dat});
    hs = s_vld & s_rdy;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        void'(srcq[p].pop_front());
        hold[p] = 1'b0;
      end else begin
        hold[p] = s_vld[p];
      end
    end
    if (r) begin
      m_busy = 1'b0; m_prev = NP - 1; m_gid = 0; m_cnt = 0;
      for (int p = 0; p < NP; p++) srcq[p].delete();
      hold = '0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        c = (m_prev + k) % NP;
        if (!found && s_vld[c]) begin
          found = 1'b1; m_owner = c;
        end
      end
      if (found) begin
        m_busy = 1'b1; m_gid = m_owner; m_cnt = 0;
        own_log.push_back(m_owner);
      end
    end else if (acc) begin
      m_cnt++;
      if (e_last) begin
        m_busy = 1'b0; m_prev = m_owner;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while (pending() && n < budget) begin
      step(1'b0);
      n++;
    end
    chk("drain_done", n < budget, 1);
  endtask

  task automatic clear_logs();
    acc_log.delete();
    own_log.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, total;
    int exp_c[5];
    rst = 1'b1; s_vld = '0; s_last = '0; s_dat = '0; s_strb = '0; m_rdy = 1'b0;
    hold = '0; gate = '1; vld_pct = 100; rdy_pct = 100; rdy_mode = 1'b0;
    m_busy = 1'b0; m_prev = NP - 1; m_gid = 0; m_cnt = 0; m_owner = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state with no requests.
    step(1'b0);
    step(1'b0);

    // Port 0 three beats 1,2,3.
    clear_logs();
    for (int b = 1; b <= 3; b++) srcq[0].push_back({(b == 3), 4'hF, 32'(b)});
    drain(100, n);
    chk("B_cycles", n, 4);
    chk("B_beats", acc_log.size(), 3);
    for (int i = 0; i < acc_log.size(); i++) begin
      chk("B_dat", acc_log[i][31:0], i + 1);
      chk("B_last", acc_log[i][32], (i == 2));
    end
    if (own_log.size() > 0) chk("B_grant", own_log[0], 0);
    else chk("B_grant_seen", own_log.size(), 1);

    // All ports two-beat packets from reset: order 0,1,2,3,0.
    step(1'b1);
    clear_logs();
    for (int p = 0; p < NP; p++) add_pkt(p, 2, 10);
    add_pkt(0, 2, 11);
    drain(200, n);
    chk("C_cycles", n, 15);
    chk("C_pkts", own_log.size(), 5);
    exp_c = '{0, 1, 2, 3, 0};
    for (int i = 0; i < own_log.size() && i < 5; i++) chk("C_order", own_log[i], exp_c[i]);

    // Port 1 stalls four cycles mid-packet while port 2 requests.
    clear_logs();
    add_pkt(1, 2, 20);
    add_pkt(2, 2, 21);
    k = 0;
    while (acc_log.size() < 1 && k < 30) begin step(1'b0); k++; end
    chk("D_first_beat", acc_log.size(), 1);
    gate[1] = 1'b0;
    repeat (4) step(1'b0);
    gate[1] = 1'b1;
    drain(100, n);
    chk("D_pkts", own_log.size(), 2);
    if (own_log.size() == 2) begin
      chk("D_own0", own_log[0], 1);
      chk("D_own1", own_log[1], 2);
    end

    // Master ready pattern 1,0,0 during a four-beat packet.
    clear_logs();
    rdy_mode = 1'b1;
    add_pkt(2, 4, 30);
    drain(200, n);
    rdy_mode = 1'b0;
    chk("E_beats", acc_log.size(), 4);
    for (int i = 0; i < acc_log.size(); i++) chk("E_order", acc_log[i][31:0], mkdat(2, 30, i));

    // Randomised traffic rounds.
    for (int rnd = 0; rnd < 5; rnd++) begin
      clear_logs();
      total = 0;
      vld_pct = $urandom_range(100, 40);
      rdy_pct = $urandom_range(100, 30);
      for (int i = 0; i < 40; i++) begin
        n = $urandom_range(6, 1);
        add_pkt($urandom_range(NP - 1), n, 100 + rnd * 40 + i);
        total += n;
      end
      drain(20000, n);
      chk("F_beats", acc_log.size(), total);
    end
    vld_pct = 100;
    rdy_pct = 100;

    // Reset after the second beat of a five-beat packet.
    step(1'b1);
    clear_logs();
    add_pkt(0, 5, 50);
    k = 0;
    while (acc_log.size() < 2 && k < 30) begin step(1'b0); k++; end
    chk("G_two_beats", acc_log.size(), 2);
    step(1'b1);
    step(1'b0);
    clear_logs();
    add_pkt(3, 2, 51);
    add_pkt(0, 2, 52);
    drain(100, n);
    if (own_log.size() > 0) chk("G_first_after_reset", own_log[0], 0);
    else chk("G_grant_seen", own_log.size(), 2);

`ifdef AXIS_ARB_MAX_BEATS_EN
    // Six-beat packet is split after MAX_BEATS beats.
    step(1'b1);
    clear_logs();
    add_pkt(0, 6, 60);
    add_pkt(1, 2, 61);
    drain(200, n);
    chk("H_beats", acc_log.size(), 8);
    chk("H_pkts", own_log.size(), 3);
    if (acc_log.size() == 8 && own_log.size() == 3) begin
      chk("H_cap_last", acc_log[3][32], 1);
      chk("H_own1", own_log[1], 1);
      chk("H_own2", own_log[2], 0);
      chk("H_tail", acc_log[6][31:0], mkdat(0, 60, 4));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_pkt_rr_arbiter.md
Name: axis_pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one AXI-Stream master port between NUM_PORTS AXI-Stream slave sources.
- Typical sources are xlnxstream-style word generators.
- A grant locks for a whole packet, from first beat to the TLAST handshake; data, strobe and last pass combinationally through a grant-selected mux.
- Sits between the stream generators and the downstream DMA/FIFO sink.

Parameters:
- NUM_PORTS, 4, number of slave requesters (2..8).
- C_AXIS_TDATA_WIDTH, 32, data width in bits (multiple of 8).
- MAX_BEATS, 16, packet beat limit; used only with the optional feature.

Ports:
- M_AXIS_ACLK  in  1  single clock, rising edge.
- M_AXIS_ARESET  in  1  reset, synchronous, active-high.
- S_AXIS_TVALID  in  NUM_PORTS  per-port valid.
- S_AXIS_TDATA  in  NUM_PORTS*C_AXIS_TDATA_WIDTH  flattened data; port i at slice [i*W +: W].
- S_AXIS_TSTRB  in  NUM_PORTS*C_AXIS_TDATA_WIDTH/8  flattened strobes.
- S_AXIS_TLAST  in  NUM_PORTS  per-port last.
- S_AXIS_TREADY  out  NUM_PORTS  per-port ready.
- M_AXIS_TVALID  out  1  master valid.
- M_AXIS_TDATA  out  C_AXIS_TDATA_WIDTH  master data.
- M_AXIS_TSTRB  out  C_AXIS_TDATA_WIDTH/8  master strobe.
- M_AXIS_TLAST  out  1  master last.
- M_AXIS_TREADY  in  1  master ready.
- GRANT_ID  out  clog2(NUM_PORTS)  currently or last granted port.
- BUSY  out  1  high while in STREAM.

Behaviour:
- Reset values:
  - state=IDLE, grant=0, last_grant=NUM_PORTS-1, so port 0 has first priority.
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TSTRB=0.
  - S_AXIS_TREADY=0, BUSY=0, GRANT_ID=0.
- State IDLE:
  - All S_AXIS_TREADY=0 and M_AXIS_TVALID=0.
  - If any S_AXIS_TVALID bit is set: grant <= first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS; next state STREAM.
  - Otherwise stay in IDLE.
- State STREAM, with g = grant:
  - M_AXIS_TVALID = S_AXIS_TVALID[g].
  - M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST = port g's slices.
  - S_AXIS_TREADY[g] = M_AXIS_TREADY; all other ready bits are 0.
  - Beat accepted when M_AXIS_TVALID && M_AXIS_TREADY.
- Leaving STREAM: an accepted beat with M_AXIS_TLAST=1 sets last_grant <= g and returns to IDLE.
- Latency:
  - 1 cycle from a valid first seen in IDLE to the first master beat offered.
  - Exactly one idle cycle between back-to-back packets.
- Master-side data outputs are zero whenever M_AXIS_TVALID=0, including in IDLE and while a granted port is stalled with TVALID low.
- Grant lock:
  - In STREAM the grant does not change, even if port g drops TVALID mid-packet or higher-priority ports assert valid.
  - Valid/data from non-granted ports are ignored and never acknowledged.
- Fairness: any continuously requesting port is granted within NUM_PORTS packets.
- Single-beat packets (TLAST on the first beat) are legal: STREAM lasts one accepted beat.
- Master backpressure: M_AXIS_TREADY=0 holds state; no beat is consumed from any slave.
- Reset mid-packet: the next cycle is IDLE with all outputs at reset values. The partial packet is abandoned without synthesising TLAST.
- GRANT_ID = grant register; it holds its value in IDLE.
- BUSY = (state==STREAM).

Optional Feature:
- Macro: AXIS_ARB_MAX_BEATS_EN.
- When defined:
  - A beat counter (width clog2(MAX_BEATS+1)) clears on grant and increments on each accepted beat.
  - When the accepted beat is number MAX_BEATS, M_AXIS_TLAST is forced to 1 and the arbiter returns to IDLE, rotating as on a normal TLAST.
  - The source's remaining beats form a new packet at its next grant.
- When undefined: no counter; packets of any length hold the grant until the source's TLAST.

Decomposition:
- Shared package axis_arb_pkg holds:
  - state encoding: IDLE=1'b0, STREAM=1'b1.
  - a rr_next function (mask, last) -> index.
- Natural sub-module: rr_pick, a purely combinational rotating priority encoder taking NUM_PORTS request bits and last_grant and returning the winner index and an any_req flag.
- The FSM and mux stay in axis_pkt_rr_arbiter.

Test Plan:
- Reset then port 0 sends 3 beats (data 1,2,3, TLAST on 3) with M_AXIS_TREADY=1:
  - M beats 1,2,3 appear on cycles t+1..t+3 with TLAST only on the third.
  - GRANT_ID=0; BUSY falls after the third beat.
- Ports 0..3 all valid with 2-beat packets tagged by port:
  - Grant order is 0,1,2,3,0.
  - One IDLE cycle between packets.
  - No interleaving of beats between ports.
- Port 1 granted, sends beat 1, then drops TVALID 4 cycles while port 2 is valid, then sends its TLAST beat:
  - Grant stays 1.
  - M_AXIS_TVALID=0 and M_AXIS_TDATA=0 during the gap.
  - S_AXIS_TREADY[2]=0 throughout.
- M_AXIS_TREADY toggles 1,0,0,1,... during a 4-beat packet: each beat is transferred exactly once, in order, and S_AXIS_TREADY[g] mirrors M_AXIS_TREADY.
- Assert M_AXIS_ARESET after the second beat of a 5-beat packet: the next cycle shows M_AXIS_TVALID=0, S_AXIS_TREADY=0, GRANT_ID=0, and port 0 wins first after release.
- With AXIS_ARB_MAX_BEATS_EN, MAX_BEATS=4, and port 0 sending 6 beats with TLAST on 6 while port 1 is valid:
  - Beat 4 is output with TLAST=1.
  - Port 1's packet follows.
  - Port 0's beats 5–6 are output afterwards as a separate packet.
